// File: rtl/edge_raster_engine.sv
// Queued wireframe triangle rasterizer: walks v0->v1->v2->v0 with Bresenham, one pixel per cycle.
// Define RASTER_CLIP_EN to suppress pixels outside the SCREEN_W x SCREEN_H window.
module edge_raster_engine #(
    parameter int COORD_W    = 10,
    parameter int COLOR_W    = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tri_valid,
    output logic                 tri_ready,
    input  logic [6*COORD_W-1:0] tri_xy,
    input  logic [COLOR_W-1:0]   tri_color,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [COORD_W-1:0]   pix_x,
    output logic [COORD_W-1:0]   pix_y,
    output logic [COLOR_W-1:0]   pix_color,
    output logic                 tri_done,
    output logic                 busy
);
    localparam int W  = COORD_W + 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = 6 * COORD_W + COLOR_W;

    localparam logic [AW:0]           PtrOne = 1;
    localparam logic signed [W-1:0]   One    = 1;
    localparam logic signed [W-1:0]   NegOne = -1;

    typedef enum logic [2:0] {StIdle, StLoad, StSetup, StStep, StDone} state_t;

    // Empty guard block keeps the clip window parameters referenced in every build.
    if (FIFO_DEPTH < 2 || SCREEN_W < 1 || SCREEN_H < 1) begin : g_param_guard
    end

    logic [TW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          full, empty, push, pop;
    logic [TW-1:0] head;

    state_t state_q, state_d;
    logic [1:0] edge_q, edge_d;
    logic [6*COORD_W-1:0] xy_q;
    logic [COLOR_W-1:0]   color_q;
    logic signed [W-1:0]  cur_x_q, cur_y_q, dx_q, dy_q, err_q, sx_q, sy_q;
    logic [COORD_W-1:0]   last_x_q, last_y_q;
    logic [COLOR_W-1:0]   last_color_q;

    logic [1:0]          q_idx;
    logic                last_edge, degenerate, visible, advance, edge_end, step_x, step_y;
    logic signed [W-1:0] px, py, qx, qy, diff_x, diff_y, adx, ady;
    logic signed [W-1:0] nx, ny, err_next;
    logic signed [W:0]   e2, dx_ext, dy_ext;

    function automatic logic signed [W-1:0] coord(input logic [6*COORD_W-1:0] xy,
                                                  input logic [1:0] v, input logic is_y);
        logic [COORD_W-1:0] c;
        c = xy[(2 * int'(v) + int'(is_y)) * COORD_W +: COORD_W];
        return {{2{c[COORD_W-1]}}, c};
    endfunction

    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = wr_ptr_q == rd_ptr_q;
    assign push      = tri_valid && !full;
    assign pop       = (state_q == StIdle) && !empty;
    assign tri_ready = !full;
    assign head      = fifo_mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {tri_color, tri_xy};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    always_comb begin
        q_idx      = (edge_q == 2'd2) ? 2'd0 : edge_q + 2'd1;
        last_edge  = edge_q == 2'd2;
        px         = coord(xy_q, edge_q, 1'b0);
        py         = coord(xy_q, edge_q, 1'b1);
        qx         = coord(xy_q, q_idx, 1'b0);
        qy         = coord(xy_q, q_idx, 1'b1);
        diff_x     = qx - px;
        diff_y     = qy - py;
        adx        = diff_x[W-1] ? -diff_x : diff_x;
        ady        = diff_y[W-1] ? -diff_y : diff_y;
        degenerate = (px == qx) && (py == qy);
    end

    always_comb begin
        e2       = {err_q, 1'b0};
        dx_ext   = {dx_q[W-1], dx_q};
        dy_ext   = {dy_q[W-1], dy_q};
        step_x   = e2 >= dy_ext;
        step_y   = e2 <= dx_ext;
        err_next = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
        nx       = cur_x_q + (step_x ? sx_q : '0);
        ny       = cur_y_q + (step_y ? sy_q : '0);
        edge_end = (nx == qx) && (ny == qy);
    end

`ifdef RASTER_CLIP_EN
    localparam logic signed [W-1:0] ScrW = W'(SCREEN_W);
    localparam logic signed [W-1:0] ScrH = W'(SCREEN_H);
    assign visible = !cur_x_q[W-1] && !cur_y_q[W-1] && (cur_x_q < ScrW) && (cur_y_q < ScrH);
`else
    assign visible = 1'b1;
`endif

    // Off-screen pixels advance without waiting for the downstream handshake.
    assign advance   = (state_q == StStep) && (pix_ready || !visible);
    assign pix_valid = (state_q == StStep) && visible;
    assign tri_done  = state_q == StDone;
    assign busy      = !empty || (state_q != StIdle);
    assign pix_x     = pix_valid ? cur_x_q[COORD_W-1:0] : last_x_q;
    assign pix_y     = pix_valid ? cur_y_q[COORD_W-1:0] : last_y_q;
    assign pix_color = pix_valid ? color_q : last_color_q;

    always_comb begin
        state_d = state_q;
        edge_d  = edge_q;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StLoad;
                    edge_d  = 2'd0;
                end
            end
            StLoad: state_d = StSetup;
            StSetup: begin
                if (!degenerate)    state_d = StStep;
                else if (last_edge) state_d = StDone;
                else                edge_d  = edge_q + 2'd1;
            end
            StStep: begin
                if (advance && edge_end) begin
                    if (last_edge) begin
                        state_d = StDone;
                    end else begin
                        state_d = StSetup;
                        edge_d  = edge_q + 2'd1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            edge_q       <= '0;
            xy_q         <= '0;
            color_q      <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
            err_q        <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            last_color_q <= '0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            if (pop) begin
                xy_q    <= head[6*COORD_W-1:0];
                color_q <= head[TW-1 -: COLOR_W];
            end
            if (state_q == StSetup) begin
                cur_x_q <= px;
                cur_y_q <= py;
                dx_q    <= adx;
                dy_q    <= -ady;
                err_q   <= adx - ady;
                sx_q    <= (qx > px) ? One : NegOne;
                sy_q    <= (qy > py) ? One : NegOne;
            end else if (advance) begin
                cur_x_q <= nx;
                cur_y_q <= ny;
                err_q   <= err_next;
            end
            if (pix_valid) begin
                last_x_q     <= cur_x_q[COORD_W-1:0];
                last_y_q     <= cur_y_q[COORD_W-1:0];
                last_color_q <= color_q;
            end
        end
    end

endmodule

// File: tb/tb_edge_raster_engine.sv
// Directed, table-driven bench for edge_raster_engine plus stall, backpressure and reset sequences.
module tb_edge_raster_engine;
    localparam int CW = 10;
    localparam int KW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          tri_valid;
    logic          tri_ready;
    logic [6*CW-1:0] tri_xy;
    logic [KW-1:0] tri_color;
    logic          pix_valid;
    logic          pix_ready;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic [KW-1:0] pix_color;
    logic          tri_done;
    logic          busy;

    edge_raster_engine #(
        .COORD_W    (CW),
        .COLOR_W    (KW),
        .FIFO_DEPTH (4),
        .SCREEN_W   (640),
        .SCREEN_H   (480)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .tri_xy    (tri_xy),
        .tri_color (tri_color),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .tri_done  (tri_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6*CW-1:0]     xy;
        logic [KW-1:0]       color;
        int                  npix;
        int                  first_n;
        int                  done_n;
        logic [8:0][CW-1:0]  px;
        logic [8:0][CW-1:0]  py;
    } vec_t;

    vec_t vecs [4];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [6*CW-1:0] mk_xy(input int x0, input int y0, input int x1,
                                              input int y1, input int x2, input int y2);
        return {CW'(y2), CW'(x2), CW'(y1), CW'(x1), CW'(y0), CW'(x0)};
    endfunction

    function automatic logic [8:0][CW-1:0] mk_pts(input int a0, input int a1, input int a2,
                                                  input int a3, input int a4, input int a5,
                                                  input int a6, input int a7, input int a8);
        logic [8:0][CW-1:0] r;
        r[0] = CW'(a0); r[1] = CW'(a1); r[2] = CW'(a2);
        r[3] = CW'(a3); r[4] = CW'(a4); r[5] = CW'(a5);
        r[6] = CW'(a6); r[7] = CW'(a7); r[8] = CW'(a8);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge after the accepting edge.
    task automatic send_tri(input logic [6*CW-1:0] xy, input logic [KW-1:0] col);
        bit acc = 1'b0;
        tri_xy    = xy;
        tri_color = col;
        tri_valid = 1'b1;
        for (int w = 0; w < 50; w++) begin
            if (tri_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("tri_accepted", 32'(acc), 32'd1);
        @(negedge clk);
        tri_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit stall_mode, input string tag);
        int cnt = 0, first = -1, done_at = -1, done_cnt = 0;
        int stall_bad = 0, col_bad = 0, overlap = 0;
        bit stalled = 1'b0;
        logic [CW-1:0] gx [16];
        logic [CW-1:0] gy [16];
        logic [CW-1:0] hx, hy;
        logic [KW-1:0] hc;
        send_tri(v.xy, v.color);
        for (int n = 0; n < 200; n++) begin
            if (stalled && !(pix_valid && pix_x == hx && pix_y == hy && pix_color == hc))
                stall_bad++;
            if (pix_valid && first < 0) first = n;
            if (pix_valid && tri_done) overlap++;
            if (tri_done) begin
                done_at = n;
                done_cnt++;
            end
            if (done_at >= 0 && n == done_at + 1) begin
                check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
                break;
            end
            pix_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_valid && pix_ready) begin
                if (cnt < 16) begin
                    gx[cnt] = pix_x;
                    gy[cnt] = pix_y;
                end
                if (pix_color != v.color) col_bad++;
                cnt++;
            end
            stalled = pix_valid && !pix_ready;
            hx = pix_x;
            hy = pix_y;
            hc = pix_color;
            @(negedge clk);
        end
        pix_ready = 1'b1;
        check({tag, "_pix_count"}, 32'(cnt), 32'(v.npix));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_with_valid"}, 32'(overlap), 32'd0);
        check({tag, "_pix_color"}, 32'(col_bad), 32'd0);
        check({tag, "_stall_hold"}, 32'(stall_bad), 32'd0);
        for (int i = 0; i < v.npix && i < cnt && i < 9; i++) begin
            check($sformatf("%s_px%0d", tag, i), 32'(gx[i]), 32'(v.px[i]));
            check($sformatf("%s_py%0d", tag, i), 32'(gy[i]), 32'(v.py[i]));
        end
        if (!stall_mode) begin
            check({tag, "_done_cycle"}, 32'(done_at), 32'(v.done_n));
            if (v.npix > 0) check({tag, "_first_pix_cycle"}, 32'(first), 32'(v.first_n));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc_cnt, k, seen;
        bit got;

        vecs[0] = '{xy: mk_xy(0, 0, 3, 0, 0, 3), color: 24'hA1B2C3, npix: 9, first_n: 3,
                    done_n: 14, px: mk_pts(0, 1, 2, 3, 2, 1, 0, 0, 0),
                    py: mk_pts(0, 0, 0, 0, 1, 2, 3, 2, 1)};
        vecs[1] = '{xy: mk_xy(0, 0, 0, 3, 3, 0), color: 24'h00FF00, npix: 9, first_n: 3,
                    done_n: 14, px: mk_pts(0, 0, 0, 0, 1, 2, 3, 2, 1),
                    py: mk_pts(0, 1, 2, 3, 2, 1, 0, 0, 0)};
        vecs[2] = '{xy: mk_xy(5, 5, 5, 5, 5, 5), color: 24'h123456, npix: 0, first_n: 0,
                    done_n: 5, px: '0, py: '0};
`ifdef RASTER_CLIP_EN
        vecs[3] = '{xy: mk_xy(-2, 0, 2, 0, -2, 0), color: 24'hFACADE, npix: 5, first_n: 5,
                    done_n: 13, px: mk_pts(0, 1, 2, 1, 0, 0, 0, 0, 0), py: '0};
`else
        vecs[3] = '{xy: mk_xy(-2, 0, 2, 0, -2, 0), color: 24'hFACADE, npix: 8, first_n: 3,
                    done_n: 13, px: mk_pts(-2, -1, 0, 1, 2, 1, 0, -1, 0), py: '0};
`endif

        rst       = 1'b1;
        tri_valid = 1'b0;
        tri_xy    = '0;
        tri_color = '0;
        pix_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tri_ready", 32'(tri_ready), 32'd1);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_tri_done", 32'(tri_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pix_xy", {pix_x, pix_y}, 32'd0);
        check("rst_pix_color", 32'(pix_color), 32'd0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

        run_vec(vecs[0], 1'b1, "stall");

        // Backpressure: one triangle parks in the FSM, four fill the FIFO.
        pix_ready = 1'b0;
        acc_cnt   = 0;
        for (int i = 0; i < 8; i++) begin
            tri_xy    = vecs[0].xy;
            tri_color = KW'(24'h000100 + i);
            tri_valid = 1'b1;
            got       = 1'b0;
            for (int w = 0; w < 12; w++) begin
                if (tri_ready) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!got) break;
            @(negedge clk);
            acc_cnt++;
        end
        tri_valid = 1'b0;
        check("bp_accepted", 32'(acc_cnt), 32'd5);
        check("bp_tri_ready_full", 32'(tri_ready), 32'd0);
        check("bp_stalled_valid", 32'(pix_valid), 32'd1);
        pix_ready = 1'b1;
        k = 0;
        for (int n = 0; n < 400; n++) begin
            if (tri_done) begin
                check($sformatf("bp_done%0d_color", k), 32'(pix_color), 32'(24'h000100 + k));
                k++;
            end
            if (k == 5 && !busy) break;
            @(negedge clk);
        end
        check("bp_done_count", 32'(k), 32'd5);
        check("bp_idle", 32'(busy), 32'd0);

        // Reset in the middle of an edge with two triangles queued.
        send_tri(vecs[0].xy, vecs[0].color);
        send_tri(vecs[1].xy, vecs[1].color);
        send_tri(vecs[1].xy, vecs[1].color);
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            if (pix_valid) seen++;
            if (seen >= 2) break;
            @(negedge clk);
        end
        check("rstmid_reached_step", 32'(seen), 32'd2);
        rst = 1'b1;
        #1;
        check("rstmid_pix_valid", 32'(pix_valid), 32'd0);
        check("rstmid_tri_done", 32'(tri_done), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_tri_ready", 32'(tri_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_queue_dropped", 32'(busy), 32'd0);
        run_vec(vecs[0], 1'b0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
